// File: rtl/phy_clk_sw_pkg.sv
// rtl/phy_clk_sw_pkg.sv - shared types and constants for the PHY clock-source switch controller
package phy_clk_sw_pkg;

  localparam int CNT_W          = 8;
  localparam int DRAIN_CYC_DEF  = 4;
  localparam int SETTLE_CYC_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SETTLE,
    ST_DONE,
    ST_STOPPED
  } sw_state_t;

endpackage

// File: rtl/phy_clk_sw_ctrl_if.sv
// rtl/phy_clk_sw_ctrl_if.sv - request/acknowledge and gate-enable bundle of the clock switch
interface phy_clk_sw_ctrl_if;

  logic sw_req;
  logic sel_req;
  logic clk_stop;
  logic en0;
  logic en1;
  logic cur_sel;
  logic sw_busy;
  logic sw_ack;

  modport master (
    output sw_req, sel_req, clk_stop,
    input  en0, en1, cur_sel, sw_busy, sw_ack
  );

  modport slave (
    input  sw_req, sel_req, clk_stop,
    output en0, en1, cur_sel, sw_busy, sw_ack
  );

endinterface

// File: rtl/phy_clk_sw_cnt.sv
// rtl/phy_clk_sw_cnt.sv - loadable down-counter with zero flag; saturates at zero
module phy_clk_sw_cnt
  import phy_clk_sw_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/phy_clk_sw_ctrl.sv
// rtl/phy_clk_sw_ctrl.sv - glitch-free clock source switch sequencer: drain both gates, enable target, settle, ack
module phy_clk_sw_ctrl
  import phy_clk_sw_pkg::*;
#(
  parameter int DRAIN_CYC  = DRAIN_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  phy_clk_sw_ctrl_if.slave sw
);

  if ((DRAIN_CYC < 1) || (DRAIN_CYC > 255)) begin : g_bad_drain
    $error("DRAIN_CYC must be within 1..255");
  end
  if ((SETTLE_CYC < 1) || (SETTLE_CYC > 255)) begin : g_bad_settle
    $error("SETTLE_CYC must be within 1..255");
  end

  // Counter is loaded with N-1 so a state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  sw_state_t        state_q, state_d;
  logic             en0_q, en0_d, en1_q, en1_d;
  logic             sel_q, sel_d, tgt_q, tgt_d;
  logic             busy_q, busy_d, ack_q, ack_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  phy_clk_sw_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      en0_q   <= 1'b1;
      en1_q   <= 1'b0;
      sel_q   <= 1'b0;
      tgt_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en0_q   <= en0_d;
      en1_q   <= en1_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sw.clk_stop)    state_d = ST_STOPPED;
        else if (sw.sw_req) state_d = (sw.sel_req != sel_q) ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN:   if (cnt_zero)     state_d = ST_SETTLE;
      ST_SETTLE:  if (cnt_zero)     state_d = ST_DONE;
      ST_DONE:    if (!sw.sw_req)   state_d = ST_IDLE;
      ST_STOPPED: if (!sw.clk_stop) state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; clk_stop outranks sw_req in IDLE.
  always_comb begin
    en0_d        = en0_q;
    en1_d        = en1_q;
    sel_d        = sel_q;
    tgt_d        = tgt_q;
    busy_d       = busy_q;
    ack_d        = ack_q;
    cnt_load     = 1'b0;
    cnt_load_val = DRAIN_LD;
    cnt_dec      = (state_q == ST_DRAIN) || (state_q == ST_SETTLE);
    unique case (state_q)
      ST_IDLE: begin
        if (sw.clk_stop) begin
          en0_d = 1'b0;
          en1_d = 1'b0;
        end else if (sw.sw_req) begin
          if (sw.sel_req != sel_q) begin
            en0_d    = 1'b0;
            en1_d    = 1'b0;
            busy_d   = 1'b1;
            tgt_d    = sw.sel_req;
            cnt_load = 1'b1;
          end else begin
            ack_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_zero) begin
          en0_d        = !tgt_q;
          en1_d        = tgt_q;
          sel_d        = tgt_q;
          cnt_load     = 1'b1;
          cnt_load_val = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          busy_d = 1'b0;
          ack_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (!sw.sw_req) ack_d = 1'b0;
      end
      ST_STOPPED: begin
        if (!sw.clk_stop) begin
          en0_d = !sel_q;
          en1_d = sel_q;
        end
      end
      default: ;
    endcase
  end

  assign sw.en0     = en0_q;
  assign sw.en1     = en1_q;
  assign sw.cur_sel = sel_q;
  assign sw.sw_busy = busy_q;
  assign sw.sw_ack  = ack_q;

endmodule

// File: tb/tb_phy_clk_sw_ctrl.sv
// tb/tb_phy_clk_sw_ctrl.sv - directed self-checking bench for phy_clk_sw_ctrl
module tb_phy_clk_sw_ctrl;

  localparam int D = 4;
  localparam int S = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic mon_on = 1'b0;
  int   gap    = 0;
  logic prev_ack = 1'b0;
  logic prev_req = 1'b0;

  always #5 clk = ~clk;

  phy_clk_sw_ctrl_if sw ();

  phy_clk_sw_ctrl #(
    .DRAIN_CYC  (D),
    .SETTLE_CYC (S)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller sits in an IDLE cycle T; runs a full switch to sel and checks the timeline.
  task automatic do_switch(input logic sel, input bit toggle);
    sw.sw_req  = 1'b1;
    sw.sel_req = sel;
    for (int k = 1; k <= D + S + 1; k++) begin
      step(1);
      if (k == 1) begin
        chk("busy_t1", sw.sw_busy, 1);
        chk("old_en_off_t1", sel ? sw.en0 : sw.en1, 0);
      end
      if (k == D) begin
        chk("drain_en0", sw.en0, 0);
        chk("drain_en1", sw.en1, 0);
      end
      if (k == D + 1) begin
        chk("new_en_on", sel ? sw.en1 : sw.en0, 1);
        chk("old_en_low", sel ? sw.en0 : sw.en1, 0);
        chk("cur_sel_new", sw.cur_sel, sel);
      end
      if (k == D + S) begin
        chk("settle_busy", sw.sw_busy, 1);
        chk("settle_ack", sw.sw_ack, 0);
      end
      if (toggle) sw.sel_req = ~sw.sel_req;
    end
    chk("done_ack", sw.sw_ack, 1);
    chk("done_busy", sw.sw_busy, 0);
    chk("done_sel", sw.cur_sel, sel);
    step(1);
    chk("ack_hold", sw.sw_ack, 1);
    sw.sw_req = 1'b0;
    step(1);
    chk("ack_clear", sw.sw_ack, 0);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("en_mutex", sw.en0 & sw.en1, 0);
      if (sw.en0 || sw.en1) begin
        if ((gap > 0) && sw.sw_busy) chk("drain_gap", gap >= D, 1);
        gap = 0;
      end else begin
        gap++;
      end
      if (prev_ack && !sw.sw_ack) chk("ack_after_req_low", prev_req, 0);
      prev_ack = sw.sw_ack;
      prev_req = sw.sw_req;
    end
  end

  initial begin
    sw.sw_req   = 1'b0;
    sw.sel_req  = 1'b0;
    sw.clk_stop = 1'b0;
    rst         = 1'b1;
    step(2);
    chk("rst_en0", sw.en0, 1);
    chk("rst_en1", sw.en1, 0);
    chk("rst_sel", sw.cur_sel, 0);
    chk("rst_busy", sw.sw_busy, 0);
    chk("rst_ack", sw.sw_ack, 0);
    rst    = 1'b0;
    mon_on = 1'b1;

    // same-source request
    sw.sw_req  = 1'b1;
    sw.sel_req = 1'b0;
    step(1);
    chk("same_ack", sw.sw_ack, 1);
    chk("same_en0", sw.en0, 1);
    chk("same_en1", sw.en1, 0);
    chk("same_busy", sw.sw_busy, 0);
    chk("same_sel", sw.cur_sel, 0);
    step(1);
    chk("same_ack_hold", sw.sw_ack, 1);
    sw.sw_req = 1'b0;
    step(1);
    chk("same_ack_clear", sw.sw_ack, 0);

    do_switch(1'b1, 1'b0);
    do_switch(1'b0, 1'b1);

    // stop and request together: stop wins
    sw.clk_stop = 1'b1;
    sw.sw_req   = 1'b1;
    sw.sel_req  = 1'b1;
    step(1);
    chk("stop_en0", sw.en0, 0);
    chk("stop_en1", sw.en1, 0);
    chk("stop_busy", sw.sw_busy, 0);
    chk("stop_ack", sw.sw_ack, 0);
    step(1);
    chk("stop_hold_en0", sw.en0, 0);
    chk("stop_hold_busy", sw.sw_busy, 0);
    sw.clk_stop = 1'b0;
    step(1);
    chk("unstop_en0", sw.en0, 1);
    chk("unstop_en1", sw.en1, 0);
    chk("unstop_busy", sw.sw_busy, 0);
    do_switch(1'b1, 1'b0);

    // plain stop with source 1 selected
    sw.clk_stop = 1'b1;
    step(1);
    chk("stop1_en0", sw.en0, 0);
    chk("stop1_en1", sw.en1, 0);
    sw.clk_stop = 1'b0;
    step(1);
    chk("unstop1_en1", sw.en1, 1);
    chk("unstop1_en0", sw.en0, 0);
    chk("unstop1_sel", sw.cur_sel, 1);

    // reset back to source 0, then reset mid-switch at T+7
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst2_sel", sw.cur_sel, 0);
    chk("rst2_en0", sw.en0, 1);
    sw.sw_req  = 1'b1;
    sw.sel_req = 1'b1;
    step(7);
    chk("mid_en1", sw.en1, 1);
    chk("mid_busy", sw.sw_busy, 1);
    rst       = 1'b1;
    sw.sw_req = 1'b0;
    step(1);
    rst = 1'b0;
    chk("abort_en0", sw.en0, 1);
    chk("abort_en1", sw.en1, 0);
    chk("abort_sel", sw.cur_sel, 0);
    chk("abort_ack", sw.sw_ack, 0);
    chk("abort_busy", sw.sw_busy, 0);
    do_switch(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/phy_clk_sw_ctrl.md
PHY_CLK_SW_CTRL -- requirements
Module: phy_clk_sw_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYC, default 4: cycles both clock-gate enables are held low during a switch (legal 1..255).
REQ-002 SHALL have parameter SETTLE_CYC, default 8: cycles after enabling the new source before completion is acknowledged (legal 1..255).
REQ-003 SHALL have port clk  input  1  control clock; one clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port sw_req  input  1  switch request; four-phase level handshake with sw_ack.
REQ-006 SHALL have port sel_req  input  1  requested source (0 = clk_in0 path, 1 = clk_in1 path); sampled only when a request is accepted.
REQ-007 SHALL have port clk_stop  input  1  level request to gate off both sources.
REQ-008 SHALL have port en0  output  1  gate enable for source 0, feeding the clock gate ahead of the clock-OR cell.
REQ-009 SHALL have port en1  output  1  gate enable for source 1.
REQ-010 SHALL have port cur_sel  output  1  currently selected source.
REQ-011 SHALL have port sw_busy  output  1  high while a switch is in progress.
REQ-012 SHALL have port sw_ack  output  1  switch-complete acknowledge.
REQ-013 SHALL register all outputs, with no combinational path from any input to any output.

Function
REQ-014 SHALL implement states IDLE, DRAIN, SETTLE, DONE and STOPPED.
REQ-015 IDLE, sw_req=1, sel_req!=cur_sel, accepted at cycle T SHALL produce the following at T+1: en[cur_sel]=0, sw_busy=1, target latched, state DRAIN.
REQ-016 SHALL hold DRAIN for exactly DRAIN_CYC cycles (T+1..T+DRAIN_CYC), with en0=en1=0 throughout.
REQ-017 At T+DRAIN_CYC+1 SHALL set en[target]=1 and cur_sel=target, then hold SETTLE for exactly SETTLE_CYC cycles.
REQ-018 At T+DRAIN_CYC+SETTLE_CYC+1 SHALL set sw_ack=1 and sw_busy=0, with state DONE.
REQ-019 IDLE, sw_req=1, sel_req==cur_sel SHALL give sw_ack=1 at T+1 (state DONE), with en0, en1 and cur_sel unchanged and sw_busy staying 0.
REQ-020 DONE SHALL hold sw_ack=1 until sw_req is sampled 0, then clear sw_ack on the next cycle and return to IDLE; no new request is accepted before that.
REQ-021 SHALL ignore changes on sel_req and sw_req while in DRAIN or SETTLE; the latched target governs.
REQ-022 IDLE with clk_stop=1 and sw_req=0 SHALL give en0=en1=0 on the next cycle, with state STOPPED.
REQ-023 If clk_stop and sw_req are both 1 in IDLE, clk_stop SHALL take priority, and the request is accepted after leaving STOPPED.
REQ-024 STOPPED with clk_stop=0 SHALL set en[cur_sel]=1 on the next cycle, with state IDLE.
REQ-025 SHALL sample clk_stop only in IDLE and STOPPED; a stop raised mid-switch takes effect after DONE exits.
REQ-026 SHALL never assert en0 and en1 simultaneously in any cycle, including across reset.
REQ-027 SHALL use an 8-bit down-counter for DRAIN and SETTLE, loaded on state entry, with the transition taken when it reaches 0; no wrap-around.

Reset
REQ-028 SHALL force the following on rst=1 at a clock edge: state IDLE, en0=1, en1=0, cur_sel=0, sw_busy=0, sw_ack=0, counter=0.
REQ-029 rst asserted mid-switch SHALL abort the switch, and the REQ-028 values SHALL appear on the next edge; en1 SHALL be low no later than en0 is high.

Structure
REQ-030 SHALL take the state enum, the default DRAIN_CYC/SETTLE_CYC constants and the counter width from shared package phy_clk_sw_pkg.
REQ-031 SHALL use one sub-module, phy_clk_sw_cnt: a loadable 8-bit down-counter with a zero flag.
REQ-032 SHALL NOT instantiate clock gates or the clock-OR cell; those live in the parent clock tree.
REQ-033 SHALL carry a parameter range check that fails elaboration for DRAIN_CYC or SETTLE_CYC of 0 or greater than 255.

Verification
REQ-034 Defaults, after reset, sw_req=1, sel_req=1 at cycle T: en0=0 at T+1; en1=1 and cur_sel=1 at T+5; sw_ack=1 and sw_busy=0 at T+13.
REQ-035 Same-source request with cur_sel=0, sel_req=0: sw_ack=1 at T+1, en0 stays 1, sw_busy stays 0.
REQ-036 Toggle sel_req every cycle during DRAIN/SETTLE: the switch completes to the target latched at T, with unchanged timing.
REQ-037 clk_stop=1 in IDLE: en0=en1=0 next cycle. clk_stop=0: en[cur_sel]=1 next cycle. Simultaneous clk_stop and sw_req: stop wins, switch starts after release.
REQ-038 rst pulsed at T+7 of a 0->1 switch: the next cycle shows en0=1, en1=0, cur_sel=0, sw_ack=0, and a fresh request then completes normally.
REQ-039 The bench SHALL carry assertions throughout: en0&en1 never both 1; both-low gap at least DRAIN_CYC on every switch; sw_ack deasserts only after sw_req is 0.
